mem_read_arbiter: RTL and testbench

Shares the single AXI read address/data channel of the memory subsystem among up to NUM_REQ read requesters (icache refill, dcache refill, uncached load). It sits next to the write buffer and reads that buffer's status so that no read can overtake a pending write to the same cache line. Only one read burst is outstanding at a time. Grants rotate round-robin.

---
 rtl/mem_read_arbiter_if.sv | 48 ++++
 rtl/mem_read_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_read_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_read_arbiter_if.sv
// Signal bundle between the read requesters / AXI read channel and mem_read_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_read_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]       i_req_valid;
  logic [NUM_REQ-1:0][31:0] i_req_addr;
  logic [NUM_REQ-1:0][7:0]  i_req_len;
  logic [NUM_REQ-1:0][2:0]  i_req_size;
  logic [NUM_REQ-1:0]       o_req_ready;
  logic [31:0]              o_rdata;
  logic [NUM_REQ-1:0]       o_rvalid;
  logic                     o_rlast;
  logic                     o_rerr;
  logic                     i_wb_empty;
  logic [31:0]              i_wb_addr;
  logic                     o_arvalid;
  logic                     i_arready;
  logic [31:0]              o_araddr;
  logic [7:0]               o_arlen;
  logic [2:0]               o_arsize;
  logic [1:0]               o_arburst;
  logic [3:0]               o_arid;
  logic                     i_rvalid;
  logic [31:0]              i_rdata;
  logic                     i_rlast;
  logic [1:0]               i_rresp;
  logic                     o_rready;
  logic                     o_busy;

  modport slave (
    input  i_req_valid, i_req_addr, i_req_len, i_req_size,
    input  i_wb_empty, i_wb_addr, i_arready,
    input  i_rvalid, i_rdata, i_rlast, i_rresp,
    output o_req_ready, o_rdata, o_rvalid, o_rlast, o_rerr,
    output o_arvalid, o_araddr, o_arlen, o_arsize, o_arburst, o_arid,
    output o_rready, o_busy
  );

  modport master (
    output i_req_valid, i_req_addr, i_req_len, i_req_size,
    output i_wb_empty, i_wb_addr, i_arready,
    output i_rvalid, i_rdata, i_rlast, i_rresp,
    input  o_req_ready, o_rdata, o_rvalid, o_rlast, o_rerr,
    input  o_arvalid, o_araddr, o_arlen, o_arsize, o_arburst, o_arid,
    input  o_rready, o_busy
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one AXI read channel among NUM_REQ requesters, one burst at a time.
// Define MEM_READ_LINE_HAZARD_EN to block only reads that hit the write-buffer head line.
module mem_read_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int LINE_WORD_NUM = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  mem_read_arbiter_if.slave bus
);

  localparam int OFF   = $clog2(LINE_WORD_NUM) + 2;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic [31:0]        addr_q, addr_d;
  logic [7:0]         len_q, len_d;
  logic [2:0]         size_q, size_d;
  logic [7:0]         beat_q, beat_d;
  logic               rerr_q, rerr_d;

  logic [NUM_REQ-1:0] hazard_s;
  logic [NUM_REQ-1:0] eligible_s;
  logic               found_s;
  logic [IDX_W-1:0]   pick_s;
  int                 idx_v;

  logic [NUM_REQ-1:0] req_ready_s;
  logic [NUM_REQ-1:0] rvalid_s;
  logic               rlast_s;
  logic               rready_s;

`ifdef MEM_READ_LINE_HAZARD_EN
  // Block only requesters whose line matches the pending write at the buffer head.
  always_comb begin
    hazard_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hazard_s[i] = ~bus.i_wb_empty &&
                    (bus.i_req_addr[i][31:OFF] == bus.i_wb_addr[31:OFF]);
    end
  end
`else
  logic unused_wb_addr_s;
  assign unused_wb_addr_s = ^bus.i_wb_addr;
  assign hazard_s = {NUM_REQ{~bus.i_wb_empty}};
`endif

  assign eligible_s = bus.i_req_valid & ~hazard_s;

  // Round-robin search: first eligible index at or after rr_ptr, with wrap-around.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    idx_v   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_v = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found_s && eligible_s[idx_v]) begin
        found_s = 1'b1;
        pick_s  = IDX_W'(idx_v);
      end else begin
        found_s = found_s;
      end
    end
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    winner_d    = winner_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    beat_d      = beat_q;
    rerr_d      = rerr_q;
    req_ready_s = '0;
    rvalid_s    = '0;
    rlast_s     = 1'b0;
    rready_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Acceptance is suppressed during reset since the latched fields would be discarded.
        if (found_s && !i_rst) begin
          req_ready_s[pick_s] = 1'b1;
          winner_d            = pick_s;
          addr_d              = bus.i_req_addr[pick_s];
          len_d               = bus.i_req_len[pick_s];
          size_d              = bus.i_req_size[pick_s];
          beat_d              = 8'd0;
          state_d             = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (bus.i_arready) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        rready_s           = 1'b1;
        rvalid_s[winner_q] = bus.i_rvalid;
        rlast_s            = bus.i_rvalid & bus.i_rlast;
        if (bus.i_rvalid) begin
          beat_d = beat_q + 8'd1;
          if (bus.i_rresp != 2'b00) begin
            rerr_d = 1'b1;
          end else begin
            rerr_d = rerr_q;
          end
          // A short or long burst still ends on rlast, but is flagged.
          if (bus.i_rlast) begin
            if (beat_q != len_q) begin
              rerr_d = 1'b1;
            end else begin
              rerr_d = rerr_d;
            end
            rr_ptr_d = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + IDX_W'(1);
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      winner_q <= '0;
      addr_q   <= 32'd0;
      len_q    <= 8'd0;
      size_q   <= 3'd0;
      beat_q   <= 8'd0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      winner_q <= winner_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      size_q   <= size_d;
      beat_q   <= beat_d;
      rerr_q   <= rerr_d;
    end
  end

  assign bus.o_req_ready = req_ready_s;
  assign bus.o_rvalid    = rvalid_s;
  assign bus.o_rlast     = rlast_s;
  assign bus.o_rready    = rready_s;
  assign bus.o_rdata     = bus.i_rdata;
  assign bus.o_rerr      = rerr_q;
  assign bus.o_arvalid   = (state_q == ST_ADDR);
  assign bus.o_araddr    = addr_q;
  assign bus.o_arlen     = len_q;
  assign bus.o_arsize    = size_q;
  assign bus.o_arburst   = (len_q != 8'd0) ? 2'b01 : 2'b00;
  assign bus.o_arid      = 4'd0;
  assign bus.o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed self-checking bench for mem_read_arbiter; the hazard scenario follows
// whichever MEM_READ_LINE_HAZARD_EN build is compiled.
module tb_mem_read_arbiter;

  localparam int NUM_REQ = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   wn;

  mem_read_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  mem_read_arbiter #(.NUM_REQ(NUM_REQ), .LINE_WORD_NUM(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_req_valid = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Runs one burst: expects a grant to idx, optional AR stall, beats up to last_at,
  // rresp error on err_beat. drop: 0 keep valids, 1 drop own, 2 drop all.
  task automatic do_burst(input int idx, input logic [31:0] addr, input logic [7:0] len,
                          input int bp, input int last_at, input int err_beat,
                          input logic [31:0] dbase, input int drop, output int waited);
    logic [NUM_REQ-1:0] oh;
    oh = NUM_REQ'(1) << idx;
    waited = 0;
    #1;
    while (bus.o_req_ready == '0 && waited < 20) begin
      @(posedge clk);
      #2;
      waited++;
    end
    chk("req_ready", {61'd0, bus.o_req_ready}, {61'd0, oh});
    next_cycle();
    if (drop == 1) bus.i_req_valid[idx] = 1'b0;
    else if (drop == 2) bus.i_req_valid = '0;
    for (int b = 0; b < bp; b++) begin
      bus.i_arready = 1'b0;
      bus.i_rvalid  = 1'b1;
      #1;
      chk("bp_arvalid", {63'd0, bus.o_arvalid}, 64'd1);
      chk("bp_araddr", {32'd0, bus.o_araddr}, {32'd0, addr});
      chk("bp_rvalid", {61'd0, bus.o_rvalid}, 64'd0);
      chk("bp_rready", {63'd0, bus.o_rready}, 64'd0);
      next_cycle();
    end
    bus.i_rvalid  = 1'b0;
    bus.i_arready = 1'b1;
    #1;
    chk("arvalid", {63'd0, bus.o_arvalid}, 64'd1);
    chk("araddr", {32'd0, bus.o_araddr}, {32'd0, addr});
    chk("arlen", {56'd0, bus.o_arlen}, {56'd0, len});
    chk("arburst", {62'd0, bus.o_arburst}, (len != 8'd0) ? 64'd1 : 64'd0);
    chk("arid", {60'd0, bus.o_arid}, 64'd0);
    chk("busy", {63'd0, bus.o_busy}, 64'd1);
    next_cycle();
    bus.i_arready = 1'b0;
    for (int k = 0; k <= last_at; k++) begin
      bus.i_rvalid = 1'b1;
      bus.i_rdata  = dbase + 32'(k);
      bus.i_rlast  = (k == last_at);
      bus.i_rresp  = (k == err_beat) ? 2'b10 : 2'b00;
      #1;
      chk("rvalid", {61'd0, bus.o_rvalid}, {61'd0, oh});
      chk("rdata", {32'd0, bus.o_rdata}, {32'd0, dbase + 32'(k)});
      chk("rlast", {63'd0, bus.o_rlast}, (k == last_at) ? 64'd1 : 64'd0);
      next_cycle();
    end
    bus.i_rvalid = 1'b0;
    bus.i_rlast  = 1'b0;
    bus.i_rresp  = 2'b00;
    #1;
    chk("busy_end", {63'd0, bus.o_busy}, 64'd0);
  endtask

  initial begin
    bus.i_req_valid = '0;
    bus.i_req_addr  = '0;
    bus.i_req_len   = '0;
    bus.i_req_size  = '0;
    bus.i_wb_empty  = 1'b1;
    bus.i_wb_addr   = 32'd0;
    bus.i_arready   = 1'b0;
    bus.i_rvalid    = 1'b0;
    bus.i_rdata     = 32'd0;
    bus.i_rlast     = 1'b0;
    bus.i_rresp     = 2'b00;

    do_reset();
    #1;
    chk("rst_busy", {63'd0, bus.o_busy}, 64'd0);
    chk("rst_arvalid", {63'd0, bus.o_arvalid}, 64'd0);
    chk("rst_rready", {63'd0, bus.o_rready}, 64'd0);
    chk("rst_rerr", {63'd0, bus.o_rerr}, 64'd0);
    chk("rst_araddr", {32'd0, bus.o_araddr}, 64'd0);
    chk("rst_arlen", {56'd0, bus.o_arlen}, 64'd0);
    chk("rst_req_ready", {61'd0, bus.o_req_ready}, 64'd0);
    next_cycle();

    // Single read: 8 beats A0..A7.
    bus.i_req_addr[0] = 32'h0000_1000;
    bus.i_req_len[0]  = 8'd7;
    bus.i_req_size[0] = 3'd2;
    bus.i_req_valid   = 3'b001;
    do_burst(0, 32'h0000_1000, 8'd7, 0, 7, -1, 32'h0000_00A0, 1, wn);
    chk("arsize", {61'd0, bus.o_arsize}, 64'd2);

    // Round robin with all three held valid.
    do_reset();
    bus.i_req_addr[0] = 32'h100; bus.i_req_len[0] = 8'd0;
    bus.i_req_addr[1] = 32'h200; bus.i_req_len[1] = 8'd0;
    bus.i_req_addr[2] = 32'h300; bus.i_req_len[2] = 8'd0;
    bus.i_req_valid   = 3'b111;
    do_burst(0, 32'h100, 8'd0, 0, 0, -1, 32'h10, 0, wn);
    do_burst(1, 32'h200, 8'd0, 0, 0, -1, 32'h20, 0, wn);
    chk("rr_turnaround", 64'(wn), 64'd0);
    do_burst(2, 32'h300, 8'd0, 0, 0, -1, 32'h30, 0, wn);
    chk("rr_turnaround", 64'(wn), 64'd0);
    do_burst(0, 32'h100, 8'd0, 0, 0, -1, 32'h40, 2, wn);
    chk("rr_turnaround", 64'(wn), 64'd0);

    // Write-buffer hazard; rr_ptr is 1 here.
    bus.i_wb_empty    = 1'b0;
    bus.i_wb_addr     = 32'h2004;
    bus.i_req_addr[0] = 32'h2010; bus.i_req_len[0] = 8'd1;
    bus.i_req_addr[1] = 32'h3000; bus.i_req_len[1] = 8'd1;
    bus.i_req_valid   = 3'b011;
`ifdef MEM_READ_LINE_HAZARD_EN
    do_burst(1, 32'h3000, 8'd1, 0, 1, -1, 32'h50, 1, wn);
    chk("haz_wait", 64'(wn), 64'd0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("haz_block", {61'd0, bus.o_req_ready}, 64'd0);
      next_cycle();
    end
    bus.i_wb_empty = 1'b1;
    do_burst(0, 32'h2010, 8'd1, 0, 1, -1, 32'h60, 1, wn);
`else
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("haz_block", {61'd0, bus.o_req_ready}, 64'd0);
      next_cycle();
    end
    bus.i_wb_empty = 1'b1;
    do_burst(1, 32'h3000, 8'd1, 0, 1, -1, 32'h50, 1, wn);
    do_burst(0, 32'h2010, 8'd1, 0, 1, -1, 32'h60, 1, wn);
`endif

    // AR backpressure: 5 stalled cycles with R valid driven.
    bus.i_req_addr[2] = 32'h4000; bus.i_req_len[2] = 8'd1;
    bus.i_req_valid   = 3'b100;
    do_burst(2, 32'h4000, 8'd1, 5, 1, -1, 32'h70, 1, wn);
    chk("rerr_clean", {63'd0, bus.o_rerr}, 64'd0);

    // rlast after 2 beats while len is 3.
    bus.i_req_addr[1] = 32'h6000; bus.i_req_len[1] = 8'd3;
    bus.i_req_valid   = 3'b010;
    do_burst(1, 32'h6000, 8'd3, 0, 1, -1, 32'h80, 1, wn);
    chk("rerr_short", {63'd0, bus.o_rerr}, 64'd1);

    // rresp error on beat 3, then sticky across a clean burst.
    do_reset();
    bus.i_req_addr[1] = 32'h7000; bus.i_req_len[1] = 8'd4;
    bus.i_req_valid   = 3'b010;
    do_burst(1, 32'h7000, 8'd4, 0, 4, 2, 32'h90, 1, wn);
    chk("rerr_resp", {63'd0, bus.o_rerr}, 64'd1);
    bus.i_req_addr[2] = 32'h7100; bus.i_req_len[2] = 8'd0;
    bus.i_req_valid   = 3'b100;
    do_burst(2, 32'h7100, 8'd0, 0, 0, -1, 32'hB0, 1, wn);
    chk("rerr_sticky", {63'd0, bus.o_rerr}, 64'd1);

    // Reset in the middle of a burst.
    bus.i_req_addr[0] = 32'h5000; bus.i_req_len[0] = 8'd7;
    bus.i_req_valid   = 3'b001;
    #1;
    chk("mr_ready", {61'd0, bus.o_req_ready}, 64'd1);
    next_cycle();
    bus.i_req_valid = '0;
    bus.i_arready   = 1'b1;
    next_cycle();
    bus.i_arready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.i_rvalid = 1'b1;
      bus.i_rdata  = 32'hC0 + 32'(k);
      next_cycle();
    end
    rst = 1'b1;
    next_cycle();
    #1;
    chk("mr_busy", {63'd0, bus.o_busy}, 64'd0);
    chk("mr_rready", {63'd0, bus.o_rready}, 64'd0);
    chk("mr_rvalid", {61'd0, bus.o_rvalid}, 64'd0);
    chk("mr_rlast", {63'd0, bus.o_rlast}, 64'd0);
    chk("mr_arvalid", {63'd0, bus.o_arvalid}, 64'd0);
    chk("mr_rerr", {63'd0, bus.o_rerr}, 64'd0);
    chk("mr_araddr", {32'd0, bus.o_araddr}, 64'd0);
    chk("mr_req_ready", {61'd0, bus.o_req_ready}, 64'd0);
    bus.i_rvalid = 1'b0;
    rst = 1'b0;
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
